// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control unit and its datapath.
// The master side is the datapath (IR opcode, ALU zero). The slave side is the control unit.
interface multicycle_control_if #(
  parameter int OP_W = 6
);
  logic [OP_W-1:0] opcode;
  logic            zero;
  logic            pc_wre;
  logic            ir_wre;
  logic            reg_wre;
  logic            dmem_wr;
  logic            alu_src_a;
  logic            alu_src_b;
  logic            ext_sel;
  logic            mem2reg;
  logic            wr_pc4;
  logic [1:0]      reg_dst;
  logic [1:0]      pc_src;
  logic [2:0]      alu_op;
  logic [3:0]      state;
  logic            halted;

  modport master (
    output opcode, zero,
    input  pc_wre, ir_wre, reg_wre, dmem_wr, alu_src_a, alu_src_b, ext_sel,
           mem2reg, wr_pc4, reg_dst, pc_src, alu_op, state, halted
  );

  modport slave (
    input  opcode, zero,
    output pc_wre, ir_wre, reg_wre, dmem_wr, alu_src_a, alu_src_b, ext_sel,
           mem2reg, wr_pc4, reg_dst, pc_src, alu_op, state, halted
  );
endinterface

// File: rtl/multicycle_control.sv
// Control-unit FSM of the multicycle CPU: sequences IF/ID/EXE/MEM/WB and
// drives the datapath enables and selects from the state and the IR opcode.
module multicycle_control #(
  parameter int              OP_W    = 6,
  parameter logic [OP_W-1:0] HALT_OP = 6'h3F
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.slave bus
);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_EXE_BR = 4'd3,
    S_EXE_LS = 4'd4,
    S_MEM    = 4'd5,
    S_WB_AL  = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_e;

  typedef enum logic [3:0] {
    I_ADD, I_SUB, I_ADDI, I_OR, I_AND, I_ORI, I_SLL, I_SLT,
    I_SW, I_LW, I_BEQ, I_J, I_JR, I_JAL, I_HALT, I_NOP
  } instr_e;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'h01);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h02);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'h10);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'h11);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'h12);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(6'h18);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6'h26);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h30);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h31);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h34);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'h38);
  localparam logic [OP_W-1:0] OP_JR   = OP_W'(6'h39);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'h3A);

  state_e     state_q, state_d;
  instr_e     instr;
  logic       pc_wre, ir_wre, reg_wre, dmem_wr;
  logic       alu_src_a, alu_src_b, ext_sel, mem2reg, wr_pc4, halted;
  logic [1:0] reg_dst, pc_src;
  logic [2:0] alu_op;

  // HALT_OP is checked first so it wins even if configured onto another opcode.
  always_comb begin
    instr = I_NOP;
    if (bus.opcode == HALT_OP) begin
      instr = I_HALT;
    end else begin
      case (bus.opcode)
        OP_ADD:  instr = I_ADD;
        OP_SUB:  instr = I_SUB;
        OP_ADDI: instr = I_ADDI;
        OP_OR:   instr = I_OR;
        OP_AND:  instr = I_AND;
        OP_ORI:  instr = I_ORI;
        OP_SLL:  instr = I_SLL;
        OP_SLT:  instr = I_SLT;
        OP_SW:   instr = I_SW;
        OP_LW:   instr = I_LW;
        OP_BEQ:  instr = I_BEQ;
        OP_J:    instr = I_J;
        OP_JR:   instr = I_JR;
        OP_JAL:  instr = I_JAL;
        default: instr = I_NOP;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (instr)
          I_J, I_JR, I_JAL, I_NOP: state_d = S_IF;
          I_HALT:                  state_d = S_HALT;
          I_BEQ:                   state_d = S_EXE_BR;
          I_LW, I_SW:              state_d = S_EXE_LS;
          default:                 state_d = S_EXE_AL;
        endcase
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_BR: state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (instr == I_SW) ? S_IF : S_WB_LD;
      S_WB_AL:  state_d = S_IF;
      S_WB_LD:  state_d = S_IF;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Selects stay at 0 in IF because the opcode there still belongs to the previous instruction.
  always_comb begin
    pc_wre    = 1'b0;
    ir_wre    = 1'b0;
    reg_wre   = 1'b0;
    dmem_wr   = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    ext_sel   = 1'b0;
    mem2reg   = 1'b0;
    wr_pc4    = 1'b0;
    reg_dst   = 2'b00;
    pc_src    = 2'b00;
    alu_op    = 3'b000;

    case (state_q)
      S_IF:     ir_wre = 1'b1;
      S_ID: begin
        pc_wre  = instr inside {I_J, I_JR, I_JAL, I_NOP};
        reg_wre = (instr == I_JAL);
      end
      S_EXE_BR: pc_wre = 1'b1;
      S_MEM: begin
        pc_wre  = (instr == I_SW);
        dmem_wr = (instr == I_SW);
      end
      S_WB_AL, S_WB_LD: begin
        pc_wre  = 1'b1;
        reg_wre = 1'b1;
      end
      default: ;
    endcase

    if (state_q != S_IF) begin
      alu_src_a = (instr == I_SLL);
      alu_src_b = instr inside {I_ADDI, I_ORI, I_LW, I_SW};
      ext_sel   = (instr != I_ORI);
      mem2reg   = (instr == I_LW);
      wr_pc4    = (instr == I_JAL);
      case (instr)
        I_ADDI, I_ORI, I_LW: reg_dst = 2'b00;
        I_JAL:               reg_dst = 2'b10;
        default:             reg_dst = 2'b01;
      endcase
      case (instr)
        I_BEQ:      pc_src = {1'b0, bus.zero};
        I_JR:       pc_src = 2'b10;
        I_J, I_JAL: pc_src = 2'b11;
        default:    pc_src = 2'b00;
      endcase
      case (instr)
        I_SUB, I_BEQ: alu_op = 3'b001;
        I_SLL:        alu_op = 3'b010;
        I_OR, I_ORI:  alu_op = 3'b011;
        I_AND:        alu_op = 3'b100;
        I_SLT:        alu_op = 3'b110;
        default:      alu_op = 3'b000;
      endcase
    end

    // A reset arriving mid-instruction must not leak a write pulse.
    if (reset) begin
      pc_wre  = 1'b0;
      ir_wre  = 1'b0;
      reg_wre = 1'b0;
      dmem_wr = 1'b0;
    end
  end

  assign halted        = (state_q == S_HALT) && !reset;
  assign bus.pc_wre    = pc_wre;
  assign bus.ir_wre    = ir_wre;
  assign bus.reg_wre   = reg_wre;
  assign bus.dmem_wr   = dmem_wr;
  assign bus.alu_src_a = alu_src_a;
  assign bus.alu_src_b = alu_src_b;
  assign bus.ext_sel   = ext_sel;
  assign bus.mem2reg   = mem2reg;
  assign bus.wr_pc4    = wr_pc4;
  assign bus.reg_dst   = reg_dst;
  assign bus.pc_src    = pc_src;
  assign bus.alu_op    = alu_op;
  assign bus.state     = state_q;
  assign bus.halted    = halted;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: walks each instruction class through
// its states and compares enables/selects against hand-computed values.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset;
  int   compareCount = 0;
  int   failCount = 0;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic z);
    bus.opcode = op;
    bus.zero   = z;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enable word layout: {state, halted, pc_wre, ir_wre, reg_wre, dmem_wr}
  task automatic expectEn(input string tag, input logic [3:0] st, input logic hl,
                          input logic pc, input logic ir, input logic rg, input logic dm);
    checkOutput({tag, "/en"},
                {23'd0, bus.state, bus.halted, bus.pc_wre, bus.ir_wre, bus.reg_wre, bus.dmem_wr},
                {23'd0, st, hl, pc, ir, rg, dm});
  endtask

  function automatic logic [11:0] mkSel(input logic a, input logic b, input logic ext,
                                        input logic m2r, input logic pc4, input logic [1:0] rdst,
                                        input logic [1:0] psrc, input logic [2:0] aop);
    return {a, b, ext, m2r, pc4, rdst, psrc, aop};
  endfunction

  task automatic expectSel(input string tag, input logic [11:0] sel);
    checkOutput({tag, "/sel"},
                {20'd0, bus.alu_src_a, bus.alu_src_b, bus.ext_sel, bus.mem2reg, bus.wr_pc4,
                 bus.reg_dst, bus.pc_src, bus.alu_op},
                {20'd0, sel});
  endtask

  logic [5:0]  aluOps [8];
  logic [11:0] aluSel [8];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required $finish");
    $fatal(1);
  end

  initial begin
    aluOps[0] = 6'h00; aluSel[0] = mkSel(0, 0, 1, 0, 0, 2'b01, 2'b00, 3'b000);
    aluOps[1] = 6'h01; aluSel[1] = mkSel(0, 0, 1, 0, 0, 2'b01, 2'b00, 3'b001);
    aluOps[2] = 6'h02; aluSel[2] = mkSel(0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b000);
    aluOps[3] = 6'h10; aluSel[3] = mkSel(0, 0, 1, 0, 0, 2'b01, 2'b00, 3'b011);
    aluOps[4] = 6'h11; aluSel[4] = mkSel(0, 0, 1, 0, 0, 2'b01, 2'b00, 3'b100);
    aluOps[5] = 6'h12; aluSel[5] = mkSel(0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b011);
    aluOps[6] = 6'h18; aluSel[6] = mkSel(1, 0, 1, 0, 0, 2'b01, 2'b00, 3'b010);
    aluOps[7] = 6'h26; aluSel[7] = mkSel(0, 0, 1, 0, 0, 2'b01, 2'b00, 3'b110);

    reset = 1'b1;
    applyStimulus(6'h00, 1'b0);
    tick();
    tick();
    expectEn("reset held", 4'd0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    expectEn("first IF", 4'd0, 0, 0, 1, 0, 0);

    // ALU instructions: IF, ID, EXE_AL, WB_AL, back to IF
    for (int i = 0; i < 8; i++) begin
      applyStimulus(aluOps[i], 1'b1);
      expectSel($sformatf("alu%0d IF", i), 12'd0);
      tick();
      expectEn($sformatf("alu%0d ID", i), 4'd1, 0, 0, 0, 0, 0);
      expectSel($sformatf("alu%0d ID", i), aluSel[i]);
      tick();
      expectEn($sformatf("alu%0d EXE", i), 4'd2, 0, 0, 0, 0, 0);
      expectSel($sformatf("alu%0d EXE", i), aluSel[i]);
      tick();
      expectEn($sformatf("alu%0d WB", i), 4'd6, 0, 1, 0, 1, 0);
      tick();
      expectEn($sformatf("alu%0d next IF", i), 4'd0, 0, 0, 1, 0, 0);
    end

    // lw: 5 cycles
    applyStimulus(6'h31, 1'b0);
    tick();
    expectEn("lw ID", 4'd1, 0, 0, 0, 0, 0);
    tick();
    expectEn("lw EXE", 4'd4, 0, 0, 0, 0, 0);
    expectSel("lw EXE", mkSel(0, 1, 1, 1, 0, 2'b00, 2'b00, 3'b000));
    tick();
    expectEn("lw MEM", 4'd5, 0, 0, 0, 0, 0);
    tick();
    expectEn("lw WB", 4'd7, 0, 1, 0, 1, 0);
    expectSel("lw WB", mkSel(0, 1, 1, 1, 0, 2'b00, 2'b00, 3'b000));
    tick();
    expectEn("lw next IF", 4'd0, 0, 0, 1, 0, 0);

    // sw: 4 cycles
    applyStimulus(6'h30, 1'b0);
    tick();
    tick();
    expectEn("sw EXE", 4'd4, 0, 0, 0, 0, 0);
    tick();
    expectEn("sw MEM", 4'd5, 0, 1, 0, 0, 1);
    expectSel("sw MEM", mkSel(0, 1, 1, 0, 0, 2'b01, 2'b00, 3'b000));
    tick();
    expectEn("sw next IF", 4'd0, 0, 0, 1, 0, 0);

    // beq taken and not taken
    for (int z = 1; z >= 0; z--) begin
      applyStimulus(6'h34, z[0]);
      tick();
      expectEn($sformatf("beq%0d ID", z), 4'd1, 0, 0, 0, 0, 0);
      tick();
      expectEn($sformatf("beq%0d EXE", z), 4'd3, 0, 1, 0, 0, 0);
      expectSel($sformatf("beq%0d EXE", z), mkSel(0, 0, 1, 0, 0, 2'b01, {1'b0, z[0]}, 3'b001));
      tick();
      expectEn($sformatf("beq%0d next IF", z), 4'd0, 0, 0, 1, 0, 0);
    end

    // jal, j, jr, undefined: all finish in ID
    applyStimulus(6'h3A, 1'b0);
    tick();
    expectEn("jal ID", 4'd1, 0, 1, 0, 1, 0);
    expectSel("jal ID", mkSel(0, 0, 1, 0, 1, 2'b10, 2'b11, 3'b000));
    tick();
    expectEn("jal next IF", 4'd0, 0, 0, 1, 0, 0);

    applyStimulus(6'h38, 1'b0);
    tick();
    expectEn("j ID", 4'd1, 0, 1, 0, 0, 0);
    expectSel("j ID", mkSel(0, 0, 1, 0, 0, 2'b01, 2'b11, 3'b000));
    tick();

    applyStimulus(6'h39, 1'b0);
    tick();
    expectEn("jr ID", 4'd1, 0, 1, 0, 0, 0);
    expectSel("jr ID", mkSel(0, 0, 1, 0, 0, 2'b01, 2'b10, 3'b000));
    tick();

    applyStimulus(6'h05, 1'b0);
    tick();
    expectEn("nop ID", 4'd1, 0, 1, 0, 0, 0);
    tick();
    expectEn("nop next IF", 4'd0, 0, 0, 1, 0, 0);

    // halt parks the FSM until reset
    applyStimulus(6'h3F, 1'b0);
    tick();
    expectEn("halt ID", 4'd1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      expectEn($sformatf("halt %0d", k), 4'd8, 1, 0, 0, 0, 0);
    end
    reset = 1'b1;
    #1;
    expectEn("halt reset held", 4'd8, 0, 0, 0, 0, 0);
    tick();
    expectEn("halt reset edge", 4'd0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    expectEn("post-halt IF", 4'd0, 0, 0, 1, 0, 0);

    // reset during MEM of sw suppresses the write
    applyStimulus(6'h30, 1'b0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    expectEn("sw MEM reset", 4'd5, 0, 0, 0, 0, 0);
    tick();
    expectEn("sw reset edge", 4'd0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    expectEn("sw reset IF", 4'd0, 0, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end
endmodule
